// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register file slice:
//   - default data/index widths and the resulting register count
//   - REG_ZERO, the hard-wired zero register index
//   - WDSel encodings used by the write-back mux that feeds wr_data
// No ports (package).
// ---------------------------------------------------------------------------
package rf_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int REG_NUM    = 2 ** ADDR_W_DEF;
   localparam int REG_ZERO   = 0;

   typedef enum logic [1:0] {
      FromALU = 2'b00,
      FromMEM = 2'b01,
      FromPC  = 2'b10
   } wdsel_e;

endpackage

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// Per-register busy vector for long-latency destinations. A reservation sets
// the busy bit, the matching write-back clears it. Also flags (sticky) a
// reservation issued to a register that is still busy.
// Optional feature macro: RF_BYPASS_EN (same-cycle busy bypass on reads).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_en, wr_addr      write-back strobe/index (clears busy)
//   rsv_en, rsv_addr    reservation strobe/index (sets busy)
//   rs1_addr, rs2_addr  read indices
//   rs1_busy, rs2_busy  busy lookups for the read indices
//   err_double_rsv      sticky double-reservation error
// ---------------------------------------------------------------------------
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic              rs1_busy,
   output logic              rs2_busy,
   output logic              err_double_rsv
);

   localparam int NREG = 2 ** ADDR_W;

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;
   logic            wr_hit;
   logic            rsv_hit;
   logic            err_set;

   always_comb begin
      wr_hit   = wr_en  && (wr_addr  != ADDR_W'(REG_ZERO));
      rsv_hit  = rsv_en && (rsv_addr != ADDR_W'(REG_ZERO));
      busy_nxt = busy;
      // Clear first, then set: a same-edge reservation belongs to the newer
      // instruction and must survive the older instruction's write-back.
      if (wr_hit)  busy_nxt[wr_addr]  = 1'b0;
      if (rsv_hit) busy_nxt[rsv_addr] = 1'b1;
      // A busy bit being released on this very edge is not a double booking.
      err_set  = rsv_hit && busy[rsv_addr] && !(wr_hit && (wr_addr == rsv_addr));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy           <= '0;
         err_double_rsv <= 1'b0;
      end else begin
         busy <= busy_nxt;
         if (err_set) err_double_rsv <= 1'b1;
      end
   end

   always_comb begin
      rs1_busy = 1'b0;
      rs2_busy = 1'b0;
      if (rs1_addr != ADDR_W'(REG_ZERO)) rs1_busy = busy[rs1_addr];
      if (rs2_addr != ADDR_W'(REG_ZERO)) rs2_busy = busy[rs2_addr];
`ifdef RF_BYPASS_EN
      // A register being written this cycle is only busy if it is also being
      // re-reserved on the same edge.
      if (wr_hit && (wr_addr == rs1_addr))
         rs1_busy = rsv_hit && (rsv_addr == rs1_addr);
      if (wr_hit && (wr_addr == rs2_addr))
         rs2_busy = rsv_hit && (rsv_addr == rs2_addr);
`endif
   end

endmodule

// File: rtl/rf_regfile_sb.sv
// ---------------------------------------------------------------------------
// rf_regfile_sb
// Register file with two combinational read ports, one synchronous write
// port (fed by the write-back mux) and a per-register busy scoreboard.
// Register x0 reads as zero and ignores writes/reservations.
// Optional feature macro: RF_BYPASS_EN -- a same-cycle write is forwarded to
// matching read ports (data and busy); otherwise reads show pre-edge state.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rs1_addr/rs2_addr             read indices
//   rs1_data/rs2_data             read data (combinational)
//   rs1_busy/rs2_busy             pending-reservation flags for read indices
//   wr_en/wr_addr/wr_data         write-back port
//   rsv_en/rsv_addr               destination reservation at issue
//   err_double_rsv                sticky double-reservation error
// ---------------------------------------------------------------------------
module rf_regfile_sb
   import rf_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic [DATA_W-1:0] rs1_data,
   output logic [DATA_W-1:0] rs2_data,
   output logic              rs1_busy,
   output logic              rs2_busy,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic              err_double_rsv
);

   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [NREG];
   logic              wr_hit;

   assign wr_hit = wr_en && (wr_addr != ADDR_W'(REG_ZERO));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wr_hit) begin
         regs[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (rs1_addr != ADDR_W'(REG_ZERO)) rs1_data = regs[rs1_addr];
      if (rs2_addr != ADDR_W'(REG_ZERO)) rs2_data = regs[rs2_addr];
`ifdef RF_BYPASS_EN
      if (wr_hit && (wr_addr == rs1_addr)) rs1_data = wr_data;
      if (wr_hit && (wr_addr == rs2_addr)) rs2_data = wr_data;
`endif
   end

   rf_scoreboard #(
      .ADDR_W (ADDR_W)
   ) u_sb (
      .clk            (clk),
      .rst            (rst),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .rsv_en         (rsv_en),
      .rsv_addr       (rsv_addr),
      .rs1_addr       (rs1_addr),
      .rs2_addr       (rs2_addr),
      .rs1_busy       (rs1_busy),
      .rs2_busy       (rs2_busy),
      .err_double_rsv (err_double_rsv)
   );

endmodule

// File: tb/tb_rf_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_rf_regfile_sb
// Scoreboard bench for rf_regfile_sb. The stimulus process drives one set of
// inputs per cycle, computes the expected read-port/error outputs from an
// array-based reference model and queues them; a monitor pops and compares
// on the falling edge. Honors RF_BYPASS_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_rf_regfile_sb;

   logic        clk;
   logic        rst;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_data, rs2_data;
   logic        rs1_busy, rs2_busy;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        rsv_en;
   logic [4:0]  rsv_addr;
   logic        err_double_rsv;

   rf_regfile_sb #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk            (clk),
      .rst            (rst),
      .rs1_addr       (rs1_addr),
      .rs2_addr       (rs2_addr),
      .rs1_data       (rs1_data),
      .rs2_data       (rs2_data),
      .rs1_busy       (rs1_busy),
      .rs2_busy       (rs2_busy),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .rsv_en         (rsv_en),
      .rsv_addr       (rsv_addr),
      .err_double_rsv (err_double_rsv)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] d1;
      logic [31:0] d2;
      logic        b1;
      logic        b2;
      logic        e;
      int          cyc;
   } exp_t;

   exp_t        q[$];
   int          nchk  = 0;
   int          npass = 0;
   int          cycn  = 0;

   // reference model state
   logic [31:0] mreg [32];
   bit          mbusy [32];
   bit          merr;

   function automatic void exp_read(input logic [4:0] a, output logic [31:0] d,
                                    output logic b);
      if (a == 5'd0) begin
         d = 32'd0;
         b = 1'b0;
      end else begin
         d = mreg[a];
         b = mbusy[a];
`ifdef RF_BYPASS_EN
         if (wr_en && wr_addr == a) begin
            d = wr_data;
            b = rsv_en && (rsv_addr == a);
         end
`endif
      end
   endfunction

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] want, input int c);
      nchk++;
      if (got === want) npass++;
      else $display("FAIL %s cyc=%0d got=%h expected=%h", name, c, got, want);
   endtask

   // monitor: one expected entry per checked cycle, compared mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("rs1_data", rs1_data, e.d1, e.cyc);
            check("rs2_data", rs2_data, e.d2, e.cyc);
            check("rs1_busy", {31'd0, rs1_busy}, {31'd0, e.b1}, e.cyc);
            check("rs2_busy", {31'd0, rs2_busy}, {31'd0, e.b2}, e.cyc);
            check("err_double_rsv", {31'd0, err_double_rsv}, {31'd0, e.e}, e.cyc);
         end
      end
   end

   task automatic cycle(input bit r, input bit we, input logic [4:0] wa,
                        input logic [31:0] wd, input bit re, input logic [4:0] ra,
                        input logic [4:0] a1, input logic [4:0] a2, input bit chk);
      exp_t e;
      bit   derr;
      rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
      rsv_en = re; rsv_addr = ra; rs1_addr = a1; rs2_addr = a2;
      if (chk) begin
         exp_read(a1, e.d1, e.b1);
         exp_read(a2, e.d2, e.b2);
         e.e   = merr;
         e.cyc = cycn;
         q.push_back(e);
      end
      @(posedge clk);
      // model update for the edge just taken
      if (r) begin
         for (int i = 0; i < 32; i++) begin
            mreg[i]  = 32'd0;
            mbusy[i] = 1'b0;
         end
         merr = 1'b0;
      end else begin
         derr = re && ra != 5'd0 && mbusy[ra] && !(we && wa == ra);
         if (we && wa != 5'd0) begin
            mreg[wa]  = wd;
            mbusy[wa] = 1'b0;
         end
         if (re && ra != 5'd0) mbusy[ra] = 1'b1;
         if (derr) merr = 1'b1;
      end
      cycn++;
      #1;
   endtask

   initial begin
      logic [4:0] a, b, c, d;
      cycle(1, 1, 5'd3, 32'h1, 1, 5'd3, 0, 0, 0);
      // reset values on every index
      for (int i = 0; i < 16; i++)
         cycle(0, 0, 0, 0, 0, 0, 5'(i), 5'(i + 16), 1);
      // basic write / x0 write
      cycle(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 5'd5, 5'd5, 1);
      cycle(0, 0, 0, 0, 0, 0, 5'd5, 5'd5, 1);
      cycle(0, 1, 5'd0, 32'h1234, 1, 5'd0, 5'd0, 5'd0, 1);
      cycle(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd5, 1);
      // reservation held then released by write-back
      cycle(0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd0, 1);
      cycle(0, 0, 0, 0, 0, 0, 5'd7, 5'd7, 1);
      cycle(0, 0, 0, 0, 0, 0, 5'd7, 5'd7, 1);
      cycle(0, 0, 0, 0, 0, 0, 5'd7, 5'd7, 1);
      cycle(0, 1, 5'd7, 32'h55, 0, 0, 5'd7, 5'd7, 1);
      cycle(0, 0, 0, 0, 0, 0, 5'd7, 5'd7, 1);
      // same-edge write + reserve, then double reservation
      cycle(0, 1, 5'd9, 32'hA, 1, 5'd9, 5'd9, 5'd9, 1);
      cycle(0, 0, 0, 0, 0, 0, 5'd9, 5'd9, 1);
      cycle(0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd9, 1);
      cycle(0, 0, 0, 0, 0, 0, 5'd9, 5'd9, 1);
      cycle(0, 1, 5'd9, 32'hB, 0, 0, 5'd9, 5'd1, 1);
      cycle(0, 0, 0, 0, 0, 0, 5'd9, 5'd1, 1);
      // same-cycle read of a register being written
      cycle(0, 1, 5'd3, 32'h11, 0, 0, 5'd3, 5'd3, 1);
      cycle(0, 1, 5'd3, 32'h77, 0, 0, 5'd0, 5'd3, 1);
      cycle(0, 0, 0, 0, 0, 0, 5'd3, 5'd3, 1);
      // reset while x4 busy and holding data, with a concurrent write
      cycle(0, 1, 5'd4, 32'h99, 1, 5'd4, 5'd4, 5'd4, 1);
      cycle(0, 0, 0, 0, 1, 5'd4, 5'd4, 5'd4, 1);
      cycle(1, 1, 5'd4, 32'h1234, 1, 5'd4, 5'd4, 5'd4, 1);
      cycle(0, 0, 0, 0, 0, 0, 5'd4, 5'd4, 1);
      // randomized traffic, indices biased to a small range for collisions
      for (int n = 0; n < 1500; n++) begin
         a = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         b = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         c = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         d = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         cycle(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1, a, $urandom,
               $urandom_range(0, 9) < 3, b, c, d, 1);
      end
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
      if (q.size() > 0) begin
         nchk++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/rf_regfile_sb.md
Name: rf_regfile_sb

Overview:
- Register file that receives the write-back data selected by the write-back mux (the receiving end of WD).
- Provides two asynchronous read ports to decode/ALU and one synchronous write port.
- Adds a per-register busy scoreboard so that multi-cycle load returns can be reserved at issue and released at write-back.
- Sits between decode (read side) and the write-back mux (write side) in the CPU datapath.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; register count = 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- rs1_addr  input  ADDR_W  read port 1 index.
- rs2_addr  input  ADDR_W  read port 2 index.
- rs1_data  output  DATA_W  read port 1 data (combinational).
- rs2_data  output  DATA_W  read port 2 data (combinational).
- rs1_busy  output  1  read port 1 register has a pending reservation.
- rs2_busy  output  1  read port 2 register has a pending reservation.
- wr_en  input  1  write strobe from write-back stage.
- wr_addr  input  ADDR_W  write index.
- wr_data  input  DATA_W  write data (WD from write-back mux).
- rsv_en  input  1  reserve destination for a pending long-latency write.
- rsv_addr  input  ADDR_W  register index to reserve.
- err_double_rsv  output  1  sticky: reservation issued to an already-busy register.

Behaviour:
- Reset:
  - One clock, synchronous, active-high reset.
  - On clk rising edge with rst=1, all registers are 0, all busy bits are 0 and err_double_rsv is 0.
  - rsv_en and wr_en are ignored in the reset cycle.
  - Reset mid-operation discards pending reservations; they are not replayed.
- Register x0:
  - Reads of index 0 always return 0 with busy 0.
  - Writes and reservations to index 0 are silently dropped and never set err_double_rsv.
- Write:
  - With wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data on the rising edge.
  - The same edge clears busy[wr_addr].
  - Write latency is 1 cycle; the value is visible on the read ports from the next cycle.
- Reserve:
  - With rsv_en=1 and rsv_addr!=0, busy[rsv_addr] <= 1 on the rising edge.
  - If busy[rsv_addr] is already 1 (and it is not being cleared by a same-cycle write to that index), err_double_rsv <= 1.
  - err_double_rsv stays set until rst.
- Simultaneous write and reserve, same index:
  - Data is written and busy ends at 1; the reservation wins because it belongs to the newer instruction.
  - No error is raised.
- Simultaneous write and reserve, different indices: both take effect independently.
- Reads:
  - Purely combinational from the index inputs and the current state.
  - rs1 and rs2 may name the same register.
  - Reading a busy register still returns its current stored value; the consumer must stall on rsX_busy.
- Widths: all indices are ADDR_W wide with no wrap handling; every index is legal.
- State: DATA_W x 2**ADDR_W data array plus a 2**ADDR_W busy vector.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined, for each read port when wr_en=1, wr_addr!=0 and wr_addr==rsX_addr:
  - rsX_data = wr_data (write-through in the same cycle).
  - rsX_busy = 1 only if rsv_en=1 and rsv_addr equals the same index; otherwise 0.
- Not defined: reads return pre-edge register contents and busy bits; the consumer sees the write one cycle later.

Decomposition:
- Package rf_pkg holds:
  - DATA_W and ADDR_W defaults;
  - REG_NUM = 2**ADDR_W;
  - the constant REG_ZERO = 0;
  - the WDSel encodings FromALU=2'b00, FromMEM=2'b01, FromPC=2'b10, shared with the write-back mux.
- One sub-module, rf_scoreboard, owns the busy vector, the set/clear priority, error detection and the busy lookups for both read ports.
- The top level holds the data array and the read/bypass muxing.

Test Plan:
- Reset then read all 32 indices -> every rsX_data=0, rsX_busy=0, err_double_rsv=0.
- Write x5=0xDEADBEEF, read rs1=5, rs2=5 next cycle -> both 0xDEADBEEF; write x0=0x1234 then read x0 -> 0.
- rsv x7; next cycle read rs1=7 -> rs1_busy=1; three cycles later wr x7=0x55 -> rs1_busy=0 and rs1_data=0x55 from the following cycle (same cycle with RF_BYPASS_EN).
- Same-edge wr x9=0xA and rsv x9 -> x9=0xA, busy[9]=1, err_double_rsv=0; a second rsv x9 without a write -> err_double_rsv=1 and it stays 1.
- With RF_BYPASS_EN, wr_en=1, wr_addr=3, wr_data=0x77, rs2_addr=3 -> rs2_data=0x77 combinationally; without the macro -> old x3 value.
- Assert rst while x4 is busy and holds 0x99 -> next cycle x4=0, busy 0, error cleared; a concurrent wr_en in the reset cycle has no effect.
